// File: rtl/demux_registrado.sv
`default_nettype none
// ============================================================================
// Module  : demux_registrado
// Brief   : Registered 1-to-CANAIS demultiplexer with valid/ready handshake and
//           one-entry holding register per channel. Optional broadcast mode is
//           enabled by defining DEMUX_BROADCAST_EN.
// Revision: 1.0 - initial release
// ============================================================================
module demux_registrado #(
   parameter int LARGURA = 8,
   parameter int CANAIS  = 4,
   parameter int SELW    = 2
) (
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic [LARGURA-1:0]        Entrada,
   input  logic [SELW-1:0]           Controle,
   input  logic                      EntradaValida,
   output logic                      EntradaPronta,
   input  logic                      Difusao,
   output logic [LARGURA*CANAIS-1:0] Saida,
   output logic [CANAIS-1:0]         SaidaValida,
   input  logic [CANAIS-1:0]         SaidaAceita,
   output logic                      Descartado
);

   typedef enum logic {
      VAZIO = 1'b0,
      CHEIO = 1'b1
   } estado_t;

   estado_t            estado_q [CANAIS];
   estado_t            estado_d [CANAIS];
   logic [LARGURA-1:0] dado_q   [CANAIS];
   logic [LARGURA-1:0] dado_d   [CANAIS];
   logic               descartado_q;
   logic               descartado_d;

   logic [CANAIS-1:0]  livre;
   logic [CANAIS-1:0]  alvo;
   logic               em_faixa;
   logic               livre_sel;
   logic               difusao_ativa;
   logic               transfere;

`ifdef DEMUX_BROADCAST_EN
   assign difusao_ativa = Difusao && EntradaValida;
`else
   logic difusao_unused;
   assign difusao_unused = Difusao;
   assign difusao_ativa  = 1'b0;
`endif

   // A full channel is still free when its consumer drains it this cycle.
   always_comb begin : p_selecao
      livre     = '0;
      alvo      = '0;
      livre_sel = 1'b0;
      em_faixa  = (int'(Controle) < CANAIS);
      for (int i = 0; i < CANAIS; i++) begin
         livre[i] = (estado_q[i] == VAZIO) || SaidaAceita[i];
         if (int'(Controle) == i) begin
            livre_sel = livre[i];
            alvo[i]   = 1'b1;
         end
      end
      if (difusao_ativa) begin
         EntradaPronta = &livre;
         alvo          = '1;
      end else if (em_faixa) begin
         EntradaPronta = livre_sel;
      end else begin
         EntradaPronta = 1'b1;
      end
      transfere = EntradaValida && EntradaPronta;
   end

   always_comb begin : p_proximo
      descartado_d = transfere && !em_faixa && !difusao_ativa;
      for (int i = 0; i < CANAIS; i++) begin
         estado_d[i] = estado_q[i];
         dado_d[i]   = dado_q[i];
         if (transfere && alvo[i]) begin
            estado_d[i] = CHEIO;
            dado_d[i]   = Entrada;
         end else if (SaidaAceita[i]) begin
            estado_d[i] = VAZIO;
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin : p_registro
      if (Reset) begin
         for (int i = 0; i < CANAIS; i++) begin
            estado_q[i] <= VAZIO;
            dado_q[i]   <= '0;
         end
         descartado_q <= 1'b0;
      end else begin
         for (int i = 0; i < CANAIS; i++) begin
            estado_q[i] <= estado_d[i];
            dado_q[i]   <= dado_d[i];
         end
         descartado_q <= descartado_d;
      end
   end

   generate
      for (genvar i = 0; i < CANAIS; i++) begin : g_saida
         assign Saida[i*LARGURA +: LARGURA] = dado_q[i];
         assign SaidaValida[i]              = (estado_q[i] == CHEIO);
      end
   endgenerate

   assign Descartado = descartado_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_registrado.sv
`default_nettype none
// ============================================================================
// Module  : tb_demux_registrado
// Brief   : Scoreboard bench for demux_registrado (4-channel and 3-channel
//           instances); broadcast cases follow DEMUX_BROADCAST_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_demux_registrado;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [7:0]  Entrada;
   logic [1:0]  Controle;
   logic        EntradaValida;
   logic        EntradaPronta;
   logic        Difusao;
   logic [31:0] Saida;
   logic [3:0]  SaidaValida;
   logic [3:0]  SaidaAceita;
   logic        Descartado;

   logic [7:0]  e3;
   logic [1:0]  c3;
   logic        v3;
   logic        pronta3;
   logic [23:0] saida3;
   logic [2:0]  valida3;
   logic [2:0]  aceita3;
   logic        desc3;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  fila [4][$];
   logic [7:0]  ult  [4];

   always #5 Clock = ~Clock;

   demux_registrado #(.LARGURA(8), .CANAIS(4), .SELW(2)) dut (
      .Clock(Clock), .Reset(Reset), .Entrada(Entrada), .Controle(Controle),
      .EntradaValida(EntradaValida), .EntradaPronta(EntradaPronta),
      .Difusao(Difusao), .Saida(Saida), .SaidaValida(SaidaValida),
      .SaidaAceita(SaidaAceita), .Descartado(Descartado)
   );

   demux_registrado #(.LARGURA(8), .CANAIS(3), .SELW(2)) dut3 (
      .Clock(Clock), .Reset(Reset), .Entrada(e3), .Controle(c3),
      .EntradaValida(v3), .EntradaPronta(pronta3),
      .Difusao(1'b0), .Saida(saida3), .SaidaValida(valida3),
      .SaidaAceita(aceita3), .Descartado(desc3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus on the 4-channel instance; checks at the falling edge.
   task automatic ciclo(input bit v, input logic [1:0] c, input logic [7:0] d,
                        input logic [3:0] ac, input bit dif, input bit exp_pronta);
      bit bc;
`ifdef DEMUX_BROADCAST_EN
      bc = dif;
`else
      bc = 1'b0;
`endif
      EntradaValida = v;
      Controle      = c;
      Entrada       = d;
      SaidaAceita   = ac;
      Difusao       = dif;
      @(negedge Clock);
      check("pronta", 32'(EntradaPronta), 32'(exp_pronta));
      check("descartado", 32'(Descartado), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("valida%0d", i), 32'(SaidaValida[i]), 32'(fila[i].size() != 0));
         if (fila[i].size() != 0) begin
            check($sformatf("dado%0d", i), 32'(Saida[i*8 +: 8]), 32'(fila[i][0]));
            if (ac[i]) void'(fila[i].pop_front());
         end else begin
            check($sformatf("retido%0d", i), 32'(Saida[i*8 +: 8]), 32'(ult[i]));
         end
      end
      if (v && exp_pronta) begin
         for (int i = 0; i < 4; i++) begin
            if (bc || (int'(c) == i)) begin
               fila[i].push_back(d);
               ult[i] = d;
            end
         end
      end
      @(posedge Clock);
      #1;
   endtask

   task automatic ocioso(input logic [3:0] ac);
      ciclo(1'b0, 2'd0, 8'h00, ac, 1'b0, (fila[0].size() == 0) || ac[0]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      Reset = 1'b0;
      EntradaValida = 1'b0; Controle = 2'd0; Entrada = 8'h00;
      SaidaAceita = 4'b0; Difusao = 1'b0;
      e3 = 8'h00; c3 = 2'd0; v3 = 1'b0; aceita3 = 3'b0;
      for (int i = 0; i < 4; i++) ult[i] = 8'h00;
      #2 Reset = 1'b1;
      #10;
      check("rst_saida", Saida, 32'd0);
      check("rst_valida", 32'(SaidaValida), 32'd0);
      check("rst_descartado", 32'(Descartado), 32'd0);
      check("rst_valida3", 32'(valida3), 32'd0);
      @(posedge Clock);
      #1 Reset = 1'b0;

      // Single word to channel 2
      ciclo(1'b1, 2'd2, 8'hA5, 4'b0000, 1'b0, 1'b1);
      ocioso(4'b0000);
      check("tp1_valida", 32'(SaidaValida), 32'h4);
      check("tp1_saida", Saida, 32'h00A5_0000);

      // Full channel 1 back-pressures, then drains with back-to-back reload
      ciclo(1'b1, 2'd1, 8'h11, 4'b0000, 1'b0, 1'b1);
      ciclo(1'b1, 2'd1, 8'h3C, 4'b0000, 1'b0, 1'b0);
      ciclo(1'b1, 2'd1, 8'h3C, 4'b0000, 1'b0, 1'b0);
      ciclo(1'b1, 2'd1, 8'h3C, 4'b0010, 1'b0, 1'b1);
      ocioso(4'b0000);
      ocioso(4'b0110);
      ocioso(4'b0000);

      // Streaming to channel 0 at one word per cycle
      for (int k = 0; k < 8; k++) ciclo(1'b1, 2'd0, 8'(k), 4'b0001, 1'b0, 1'b1);
      ocioso(4'b0001);

      // Transfer to channel 3 while consumer 1 drains
      ciclo(1'b1, 2'd1, 8'h77, 4'b0000, 1'b0, 1'b1);
      ciclo(1'b1, 2'd3, 8'h88, 4'b0010, 1'b0, 1'b1);
      ocioso(4'b1000);

      // Asynchronous reset between edges
      ciclo(1'b1, 2'd0, 8'hB0, 4'b0000, 1'b0, 1'b1);
      ciclo(1'b1, 2'd1, 8'hB1, 4'b0000, 1'b0, 1'b1);
      ciclo(1'b1, 2'd3, 8'hB3, 4'b0000, 1'b0, 1'b1);
      EntradaValida = 1'b0;
      check("pre_reset_valida", 32'(SaidaValida), 32'hB);
      #2 Reset = 1'b1;
      #1;
      check("async_valida", 32'(SaidaValida), 32'd0);
      check("async_saida", Saida, 32'd0);
      for (int i = 0; i < 4; i++) begin
         fila[i].delete();
         ult[i] = 8'h00;
      end
      @(posedge Clock);
      #1 Reset = 1'b0;
      ocioso(4'b0000);

`ifdef DEMUX_BROADCAST_EN
      ciclo(1'b1, 2'd0, 8'h5A, 4'b0000, 1'b1, 1'b1);
      ocioso(4'b0000);
      check("bc_valida", 32'(SaidaValida), 32'hF);
      check("bc_saida", Saida, 32'h5A5A_5A5A);
      ocioso(4'b0111);
      ciclo(1'b1, 2'd0, 8'h6B, 4'b0000, 1'b1, 1'b0);
      ocioso(4'b0000);
      check("bc_bloq_valida", 32'(SaidaValida), 32'h8);
      ocioso(4'b1000);
`else
      ciclo(1'b1, 2'd2, 8'h5A, 4'b0000, 1'b1, 1'b1);
      ocioso(4'b0000);
      check("sem_difusao_valida", 32'(SaidaValida), 32'h4);
      ocioso(4'b0100);
`endif

      // Out-of-range destination on the 3-channel instance
      e3 = 8'h42; c3 = 2'd0; v3 = 1'b1;
      @(negedge Clock);
      check("d3_pronta_ch0", 32'(pronta3), 32'd1);
      check("d3_desc_ini", 32'(desc3), 32'd0);
      @(posedge Clock);
      #1 e3 = 8'hFF; c3 = 2'd3; v3 = 1'b1;
      @(negedge Clock);
      check("d3_pronta_oor", 32'(pronta3), 32'd1);
      check("d3_valida_antes", 32'(valida3), 32'h1);
      check("d3_desc_antes", 32'(desc3), 32'd0);
      @(posedge Clock);
      #1 v3 = 1'b0;
      @(negedge Clock);
      check("d3_desc_pulso", 32'(desc3), 32'd1);
      check("d3_valida_depois", 32'(valida3), 32'h1);
      check("d3_saida", 32'(saida3), 32'h42);
      @(posedge Clock);
      @(negedge Clock);
      check("d3_desc_fim", 32'(desc3), 32'd0);
      check("d3_valida_fim", 32'(valida3), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/demux_registrado.md
Name: demux_registrado

Overview:
- Registered 1-to-N demultiplexer with valid/ready handshake; the write-side counterpart of the 2:1/N:1 selectors in the datapath.
- Steers one input word to one of CANAIS output channels chosen by Controle.
- Each channel holds its word in a one-entry register until its consumer accepts it.
- Used where one producer (e.g. ALU result) feeds several registered destinations.

Parameters:
- LARGURA, 8, data width in bits.
- CANAIS, 4, number of output channels (2..16).
- SELW, 2, width of Controle; must satisfy 2^SELW >= CANAIS.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Entrada  in  LARGURA  input data word.
- Controle  in  SELW  destination channel index.
- EntradaValida  in  1  producer offers Entrada/Controle this cycle.
- EntradaPronta  out  1  block accepts this cycle (combinational).
- Difusao  in  1  broadcast request (used only with DEMUX_BROADCAST_EN).
- Saida  out  LARGURA*CANAIS  channel i data at bits [i*LARGURA +: LARGURA].
- SaidaValida  out  CANAIS  bit i set: channel i holds an unconsumed word.
- SaidaAceita  in  CANAIS  bit i: consumer i takes its word this cycle.
- Descartado  out  1  one-cycle pulse: a word addressed to Controle >= CANAIS was dropped.

Behaviour:
- Reset (async, active-high): all Saida bits 0, SaidaValida 0, Descartado 0. Asserting Reset mid-transfer discards all held words immediately. First transfer is possible on the first rising edge after Reset deasserts.
- Transfer: occurs on a rising edge when EntradaValida && EntradaPronta.
- Channel i is free when SaidaValida[i]==0 or SaidaAceita[i]==1 in the same cycle (pass-through drain).
- EntradaPronta:
  - Controle < CANAIS: EntradaPronta = free(Controle).
  - Controle >= CANAIS: EntradaPronta = 1.
- Latency: one cycle. Word captured at edge k is visible on Saida slice i with SaidaValida[i]=1 after edge k.
- Per-channel state (two states, VAZIO/CHEIO = SaidaValida[i]):
  - VAZIO + transfer to i -> CHEIO, data loaded.
  - CHEIO + SaidaAceita[i] without transfer -> VAZIO; data slice holds its last value.
  - CHEIO + SaidaAceita[i] + transfer to i -> stays CHEIO, new data loaded (back-to-back, full throughput).
  - CHEIO without accept: data and valid held stable. EntradaPronta is low only while Controle addresses this channel.
- SaidaAceita[i] while VAZIO: ignored.
- Out-of-range Controle: when Controle >= CANAIS and a transfer occurs, no channel changes and Descartado=1 for exactly the following cycle. Otherwise Descartado=0.
- EntradaValida low: no state change. EntradaPronta still reflects the rule above.
- Channels are independent. Consumers on other channels may accept in the same cycle as a transfer to channel i.

Optional Feature:
- Macro: DEMUX_BROADCAST_EN.
- Defined: when Difusao=1 with EntradaValida=1, Controle is ignored.
  - EntradaPronta = AND of free(i) over all channels.
  - On transfer, every channel loads Entrada and becomes CHEIO.
  - Descartado is never raised for a broadcast.
- Undefined: the Difusao input is ignored; behaviour is exactly the base rules.

Test Plan:
- Reset release, then Entrada=8'hA5, Controle=2, EntradaValida=1 for one cycle -> next cycle SaidaValida=4'b0100, Saida[23:16]=8'hA5, all other channels unchanged at 0.
- Channel 1 CHEIO, SaidaAceita=0, producer offers 8'h3C to Controle=1 -> EntradaPronta=0 and Saida[15:8] holds its old value. Raise SaidaAceita[1] -> EntradaPronta=1 in the same cycle; next cycle Saida[15:8]=8'h3C, SaidaValida[1] stays 1.
- CANAIS=3, Controle=3, Entrada=8'hFF, EntradaValida=1 -> EntradaPronta=1, Descartado=1 for exactly one cycle, SaidaValida unchanged.
- Streaming 8'h00..8'h07 to channel 0 with SaidaAceita[0] held high -> one word per cycle, consumer sees values in order, no gaps.
- Assert Reset asynchronously (between edges) while SaidaValida=4'b1011 -> outputs clear to 0 immediately, without waiting for the next edge.
- With DEMUX_BROADCAST_EN: Difusao=1, Entrada=8'h5A, all channels VAZIO -> next cycle SaidaValida=4'b1111, all slices 8'h5A. Repeat with channel 3 CHEIO and not accepting -> EntradaPronta=0 and no channel changes.
